avs_sample_memory: RTL and testbench
====================================

// Module: avs_sample_memory
// PURPOSE
//  Avalon-MM responder (slave) for the accelerator's sample-memory master port: serves 32-bit word
//  reads/writes of audio samples with programmable wait states driven through waitrequest.
//  Sits opposite the accelerator master in system sims/FPGA builds as on-chip sample RAM.
//  Side load/dump port lets the host or bench fill input samples and read back echo output.
// PARAMETERS
//  DATA_WIDTH   32           word width (readdata/writedata/load data)
//  ADDR_WIDTH   32           Avalon byte-address width
//  DEPTH_LOG2   12           log2 of word count (4096 words)
//  BASE_ADDR    32'h0000_0000 byte address of word 0 (word aligned)
//  READ_WAIT    2            read wait states, legal >=1
//  WRITE_WAIT   1            write wait states, legal >=0
// PORTS
//  csi_clock_clk               in   1           clock, all logic on rising edge
//  csi_clock_reset_n           in   1           reset, asynchronous assert, active-low
//  avs_mem_address             in   ADDR_WIDTH  byte address from master
//  avs_mem_read                in   1           read request
//  avs_mem_write               in   1           write request
//  avs_mem_writedata           in   DATA_WIDTH  write data
//  avs_mem_waitrequest         out  1           high = transfer not yet accepted
//  avs_mem_readdata            out  DATA_WIDTH  read data, valid when read & ~waitrequest
//  load_en                     in   1           side-port write strobe
//  load_addr                   in   DEPTH_LOG2  side-port word index
//  load_data                   in   DATA_WIDTH  side-port write data
//  load_ready                  out  1           side port accepted this cycle (Avalon FSM in IDLE)
//  dump_addr                   in   DEPTH_LOG2  side-port read index
//  dump_data                   out  DATA_WIDTH  mem[dump_addr], 1-cycle registered latency
//  err                         out  1           sticky protocol/range error
//  err_clr                     in   1           synchronous clear of err
// BEHAVIOUR
//  Reset (async, low): FSM=IDLE, wait counter=0, readdata=0, dump_data=0, err=0, waitrequest=1
//   while reset is low; memory contents NOT reset. Mid-transfer reset aborts it, no write done.
//  Word index = (address-BASE_ADDR)>>2; address bits[1:0] ignored. In range iff index<2**DEPTH_LOG2.
//  FSM IDLE/WAIT/ACK. waitrequest = 1 unless state==ACK, or IDLE with write and WRITE_WAIT==0.
//   IDLE: read -> WAIT, cnt=READ_WAIT-1 (or ACK if READ_WAIT==1 after 1 cycle); write -> WAIT,
//   cnt=WRITE_WAIT-1, or completes in-cycle if WRITE_WAIT==0 (mem written on that edge).
//   WAIT: cnt decrements each cycle; at cnt==0 -> ACK. Read data registered into readdata on
//   WAIT->ACK edge. ACK: one cycle, waitrequest=0; write commits on the ACK edge; -> IDLE.
//  Read latency: read first seen in cycle 0 -> waitrequest low in cycle READ_WAIT; write likewise
//   low in cycle WRITE_WAIT. Master must hold address/data/command stable until accepted.
//  Back-to-back: IDLE re-samples commands the cycle after ACK (one idle bubble min).
//  read & write together in IDLE: write serviced, read ignored, err set.
//  Command dropped while in WAIT: return to IDLE next cycle, no write, err set.
//  Out-of-range: handshake completes normally; write discarded; readdata=0; err set.
//  readdata holds last value outside ACK. err_clr loses to a same-cycle new error (err stays 1).
//  Side port: load_ready = (state==IDLE) & ~read & ~write; load writes mem only when load_en &
//   load_ready; otherwise dropped silently (host must retry). dump port always active, read-only.
// TESTING
//  1 Reset: csi_clock_reset_n=0 mid-read -> waitrequest=1, readdata=0, err=0; after release idle.
//  2 load words 0..3 = 0x11,0x22,0x33,0x44; READ_WAIT=2 read addr 0x8 -> waitrequest low in
//    cycle 2 with readdata=0x33; dump_addr=3 -> dump_data=0x44 next cycle.
//  3 WRITE_WAIT=0 write 0xCAFE to 0x4 -> waitrequest=0 same cycle; read 0x4 returns 0xCAFE.
//  4 Write to index 2**DEPTH_LOG2 -> completes, err=1, memory unchanged; err_clr -> err=0.
//  5 read&write both high at 0x0 -> write 0xBEEF applied, err=1; read drop during WAIT -> IDLE, err=1.
//  6 Random 1000 master reads/writes vs scoreboard, load_en contention -> load lands only when
//    load_ready=1; all read data match model.

Source files
------------

// File: rtl/avs_sample_memory_if.sv
// Avalon-MM sample-memory bus between the accelerator master and the
// sample RAM responder.
//   address     byte address driven by the master
//   read/write  command strobes, held until waitrequest drops
//   writedata   write data, held with the command
//   waitrequest responder stall, low for the accepting cycle
//   readdata    read data, valid when read & ~waitrequest
interface avs_sample_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  waitrequest;
    logic [DATA_WIDTH-1:0] readdata;

    modport master (
        output address, read, write, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avs_sample_memory.sv
// On-chip sample RAM answering the accelerator's Avalon-MM master with a
// programmable number of wait states, plus a host side port for loading
// input samples and dumping results.
//   csi_clock_clk / csi_clock_reset_n  clock, async active-low reset
//   avs_mem                            Avalon-MM slave (avs_sample_memory_if)
//   load_en/load_addr/load_data        side-port write, taken when load_ready
//   load_ready                         side port accepted this cycle
//   dump_addr/dump_data                side-port read, one cycle latency
//   err / err_clr                      sticky protocol/range error and clear
module avs_sample_memory #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    READ_WAIT  = 2,
    parameter int                    WRITE_WAIT = 1
) (
    input  logic                  csi_clock_clk,
    input  logic                  csi_clock_reset_n,
    avs_sample_memory_if.slave    avs_mem,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic [DEPTH_LOG2-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  err,
    input  logic                  err_clr
);
    localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    // The IDLE cycle and the final WAIT cycle both count as wait states, so
    // the counter is loaded with W-2 to drop waitrequest in cycle W.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'((READ_WAIT  >= 2) ? READ_WAIT  - 2 : 0);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'((WRITE_WAIT >= 2) ? WRITE_WAIT - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  op_write_q, op_write_d;
    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] readdata_q;
    logic [ADDR_WIDTH-1:0] word_off;
    logic [DEPTH_LOG2-1:0] index;
    logic                  in_range;
    logic                  waitrequest;
    logic                  new_err;
    logic                  rd_capture;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Word offset from the base; addresses below BASE_ADDR wrap high and
    // land out of range.
    assign word_off = (avs_mem.address >> 2) - (BASE_ADDR >> 2);
    assign index    = word_off[DEPTH_LOG2-1:0];
    assign in_range = (word_off[ADDR_WIDTH-1:DEPTH_LOG2] == '0);

    assign avs_mem.waitrequest = waitrequest;
    assign avs_mem.readdata    = readdata_q;

    always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
        if (!csi_clock_reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            err        <= (err & ~err_clr) | new_err;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_write_d  = op_write_q;
        waitrequest = 1'b1;
        new_err     = 1'b0;
        rd_capture  = 1'b0;
        load_ready  = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = load_addr;
        mem_wdata   = load_data;

        case (state_q)
            IDLE: begin
                load_ready = ~avs_mem.read & ~avs_mem.write;
                if (avs_mem.write) begin
                    op_write_d = 1'b1;
                    if (avs_mem.read) new_err = 1'b1;
                    if (WRITE_WAIT == 0) begin
                        waitrequest = 1'b0;
                        mem_we      = in_range;
                        mem_waddr   = index;
                        mem_wdata   = avs_mem.writedata;
                        if (!in_range) new_err = 1'b1;
                    end else if (WRITE_WAIT == 1) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WR_LOAD;
                    end
                end else if (avs_mem.read) begin
                    op_write_d = 1'b0;
                    if (READ_WAIT <= 1) begin
                        state_d    = ACK;
                        rd_capture = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = RD_LOAD;
                    end
                end else if (load_en) begin
                    mem_we = 1'b1;
                end
            end
            WAIT: begin
                if (!(op_write_q ? avs_mem.write : avs_mem.read)) begin
                    // Master abandoned the command before it was accepted.
                    state_d = IDLE;
                    cnt_d   = '0;
                    new_err = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d    = ACK;
                    rd_capture = ~op_write_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                waitrequest = 1'b0;
                state_d     = IDLE;
                if (op_write_q) begin
                    mem_we    = in_range;
                    mem_waddr = index;
                    mem_wdata = avs_mem.writedata;
                end
                if (!in_range) new_err = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (!csi_clock_reset_n) begin
            waitrequest = 1'b1;
            mem_we      = 1'b0;
            load_ready  = 1'b0;
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge csi_clock_clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
        if (!csi_clock_reset_n) begin
            readdata_q <= '0;
            dump_data  <= '0;
        end else begin
            if (rd_capture) readdata_q <= in_range ? mem[index] : '0;
            dump_data <= mem[dump_addr];
        end
    end
endmodule

// File: tb/tb_avs_sample_memory.sv
// Scoreboard bench for avs_sample_memory: instance dut_a uses 2 read / 1
// write wait states, dut_b uses 1 read / 0 write wait states.
module tb_avs_sample_memory;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel_b = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writedata = '0;
    logic        load_en = 1'b0;
    logic [11:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic [11:0] dump_addr = '0;
    logic        err_clr = 1'b0;

    logic        load_ready_a, load_ready_b, err_a, err_b;
    logic [31:0] dump_data_a, dump_data_b;

    int tests = 0;
    int fails = 0;
    int lat_cnt = 0;
    int loads_landed = 0;
    logic [31:0] model [32];

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    avs_sample_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_a ();
    avs_sample_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_b ();

    assign bus_a.address   = address;
    assign bus_a.writedata = writedata;
    assign bus_a.read      = rd & ~sel_b;
    assign bus_a.write     = wr & ~sel_b;
    assign bus_b.address   = address;
    assign bus_b.writedata = writedata;
    assign bus_b.read      = rd & sel_b;
    assign bus_b.write     = wr & sel_b;

    avs_sample_memory #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(12),
        .BASE_ADDR(32'h0), .READ_WAIT(2), .WRITE_WAIT(1)
    ) dut_a (
        .csi_clock_clk(clk), .csi_clock_reset_n(rst_n), .avs_mem(bus_a),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready_a), .dump_addr(dump_addr), .dump_data(dump_data_a),
        .err(err_a), .err_clr(err_clr)
    );

    avs_sample_memory #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(12),
        .BASE_ADDR(32'h0), .READ_WAIT(1), .WRITE_WAIT(0)
    ) dut_b (
        .csi_clock_clk(clk), .csi_clock_reset_n(rst_n), .avs_mem(bus_b),
        .load_en(1'b0), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready_b), .dump_addr(dump_addr), .dump_data(dump_data_b),
        .err(err_b), .err_clr(err_clr)
    );

    logic        cur_wait;
    logic [31:0] cur_rdata;
    always_comb begin
        cur_wait  = sel_b ? bus_b.waitrequest : bus_a.waitrequest;
        cur_rdata = sel_b ? bus_b.readdata : bus_a.readdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: every accepted transfer pops one expectation; also tracks
    // side-port loads that actually landed in dut_a.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (rd || wr)) begin
            if (cur_wait) begin
                lat_cnt++;
            end else begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL accept: unexpected transfer at 0x%08h", address);
                end else begin
                    e = exp_q.pop_front();
                    if (lat_cnt != e.lat) begin
                        fails++;
                        $display("FAIL latency @0x%08h: got %0d expected %0d", address, lat_cnt, e.lat);
                    end
                    if (e.chk_data) begin
                        tests++;
                        if (cur_rdata !== e.data) begin
                            fails++;
                            $display("FAIL readdata @0x%08h: got 0x%08h expected 0x%08h",
                                     address, cur_rdata, e.data);
                        end
                    end
                end
                lat_cnt = 0;
            end
        end else begin
            lat_cnt = 0;
        end
        if (rst_n && load_en && load_ready_a && load_addr < 12'd32) begin
            model[load_addr[4:0]] = load_data;
            loads_landed++;
        end
    end

    // Issue one master transfer; caller is at posedge+1, returns at posedge+1.
    task automatic xfer(input logic b, input logic do_rd, input logic do_wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] expd, input int lat);
        int n;
        exp_q.push_back('{chk_data: do_rd & ~do_wr, data: expd, lat: lat});
        sel_b = b;
        address = a;
        writedata = d;
        rd = do_rd;
        wr = do_wr;
        n = 0;
        forever begin
            @(negedge clk);
            if (!cur_wait) break;
            n++;
            if (n > 40) begin
                tests++;
                fails++;
                $display("FAIL timeout @0x%08h: no accept within 40 cycles", a);
                break;
            end
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
        sel_b = 1'b0;
    endtask

    task automatic load(input logic [11:0] idx, input logic [31:0] d);
        load_en = 1'b1;
        load_addr = idx;
        load_data = d;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitrequest", {31'b0, bus_a.waitrequest}, 32'h1);
        check("rst_readdata", bus_a.readdata, 32'h0);
        check("rst_err", {31'b0, err_a}, 32'h0);
        check("rst_dump", dump_data_a, 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_load_ready", {31'b0, load_ready_a}, 32'h1);

        // load, read with 2 wait states, dump
        load(12'd0, 32'h11);
        load(12'd1, 32'h22);
        load(12'd2, 32'h33);
        load(12'd3, 32'h44);
        xfer(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h33, 2);
        check("dump_before", dump_data_a, 32'h11);
        dump_addr = 12'd3;
        tick();
        check("dump_3", dump_data_a, 32'h44);
        dump_addr = 12'd0;
        tick();

        // reset in the middle of a read
        address = 32'h8;
        rd = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrd_waitrequest", {31'b0, bus_a.waitrequest}, 32'h1);
        check("midrd_readdata", bus_a.readdata, 32'h0);
        check("midrd_err", {31'b0, err_a}, 32'h0);
        rd = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", {31'b0, load_ready_a}, 32'h1);
        xfer(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h33, 2);

        // reset in the middle of a write: nothing committed
        address = 32'h0;
        writedata = 32'h5555;
        wr = 1'b1;
        #2 rst_n = 1'b0;
        #1 wr = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("midwr_no_commit", dump_data_a, 32'h11);

        // out-of-range write, err and clear
        xfer(1'b0, 1'b0, 1'b1, 32'h4000, 32'hDEAD, 32'h0, 1);
        check("oor_wr_err", {31'b0, err_a}, 32'h1);
        tick();
        check("oor_wr_mem0", dump_data_a, 32'h11);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", {31'b0, err_a}, 32'h0);

        // out-of-range read with clear held: new error wins
        err_clr = 1'b1;
        xfer(1'b0, 1'b1, 1'b0, 32'h4000, 32'h0, 32'h0, 2);
        err_clr = 1'b0;
        check("clr_vs_new_err", {31'b0, err_a}, 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // read and write together: write wins, error flagged
        xfer(1'b0, 1'b1, 1'b1, 32'h0, 32'hBEEF, 32'h0, 1);
        check("rw_both_err", {31'b0, err_a}, 32'h1);
        tick();
        check("rw_both_mem0", dump_data_a, 32'hBEEF);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // read dropped while waiting
        address = 32'h8;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        check("drop_err", {31'b0, err_a}, 32'h1);
        check("drop_idle", {31'b0, load_ready_a}, 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // zero write wait states on dut_b
        xfer(1'b1, 1'b0, 1'b1, 32'h4, 32'hCAFE, 32'h0, 0);
        xfer(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 32'hCAFE, 1);
        check("b_err", {31'b0, err_b}, 32'h0);

        // random traffic on words 16..31 with competing side-port loads
        for (int i = 16; i < 32; i++) load(12'(i), 32'hA000_0000 + 32'(i));
        begin
            logic done;
            done = 1'b0;
            fork
                begin
                    for (int t = 0; t < 1000; t++) begin
                        int unsigned idx;
                        logic [31:0] a, d;
                        idx = 16 + $urandom_range(0, 15);
                        a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
                        if ($urandom_range(0, 1) == 1) begin
                            d = $urandom;
                            model[idx] = d;
                            xfer(1'b0, 1'b0, 1'b1, a, d, 32'h0, 1);
                        end else begin
                            xfer(1'b0, 1'b1, 1'b0, a, 32'h0, model[idx], 2);
                        end
                        repeat ($urandom_range(0, 2)) tick();
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1;
                        load_en = ($urandom_range(0, 1) == 1);
                        load_addr = 12'(16 + $urandom_range(0, 15));
                        load_data = $urandom;
                    end
                    load_en = 1'b0;
                end
            join
        end
        tick();
        for (int i = 16; i < 32; i++) begin
            dump_addr = 12'(i);
            tick();
            check($sformatf("dump_%0d", i), dump_data_a, model[i]);
        end
        check("rand_err", {31'b0, err_a}, 32'h0);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
